// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 16-bit x^16+x^14+x^13+x^11+1 pattern generator.
// Define LFSR_CHECKER_RELOCK_EN to let LOCKED fall back to HUNT after LOSS_THRESH consecutive mismatches.
module lfsr_checker #(
    parameter int LOCK_COUNT  = 4,
    parameter int LOSS_THRESH = 8,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [15:0]          data_in,
    input  logic                 data_valid,
    input  logic                 err_clr,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

    if (LOCK_COUNT < 1 || LOCK_COUNT > 15) begin : g_bad_lock_count
        $error("LOCK_COUNT must be within 1..15");
    end
    if (LOSS_THRESH < 1 || LOSS_THRESH > 255) begin : g_bad_loss_thresh
        $error("LOSS_THRESH must be within 1..255");
    end

    state_t               state_reg, state_next;
    logic [15:0]          expected_reg, expected_next;
    logic [3:0]           match_cnt_reg, match_cnt_next;
    logic                 locked_reg, locked_next;
    logic                 err_pulse_reg, err_pulse_next;
    logic [ERR_CNT_W-1:0] err_count_reg, err_count_next;
    logic                 is_match;
`ifdef LFSR_CHECKER_RELOCK_EN
    localparam logic [7:0] LOSS_LIMIT = 8'(LOSS_THRESH);
    logic [7:0]           consec_err_reg, consec_err_next;
`endif

    function automatic logic [15:0] nxt(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    assign is_match = (data_in == expected_reg);

    always_comb begin
        state_next     = state_reg;
        expected_next  = expected_reg;
        match_cnt_next = match_cnt_reg;
        err_pulse_next = 1'b0;
        err_count_next = err_count_reg;
`ifdef LFSR_CHECKER_RELOCK_EN
        consec_err_next = consec_err_reg;
`endif
        if (data_valid) begin
            case (state_reg)
                HUNT: begin
                    if (data_in != 16'h0000) begin
                        expected_next  = nxt(data_in);
                        match_cnt_next = 4'd0;
                        state_next     = VERIFY;
                    end
                end
                VERIFY: begin
                    if (is_match) begin
                        expected_next  = nxt(data_in);
                        match_cnt_next = match_cnt_reg + 4'd1;
                        if (match_cnt_reg + 4'd1 == LOCK_TARGET) begin
                            state_next = LOCKED;
`ifdef LFSR_CHECKER_RELOCK_EN
                            consec_err_next = 8'd0;
`endif
                        end
                    end else if (data_in != 16'h0000) begin
                        expected_next  = nxt(data_in);
                        match_cnt_next = 4'd0;
                    end else begin
                        state_next = HUNT;
                    end
                end
                LOCKED: begin
                    // Free-run on our own prediction so a corrupted word cannot pull us off sequence.
                    expected_next = nxt(expected_reg);
                    if (is_match) begin
`ifdef LFSR_CHECKER_RELOCK_EN
                        consec_err_next = 8'd0;
`endif
                    end else begin
                        err_pulse_next = 1'b1;
                        if (err_count_reg != '1) begin
                            err_count_next = err_count_reg + ERR_CNT_W'(1);
                        end
`ifdef LFSR_CHECKER_RELOCK_EN
                        if (consec_err_reg != 8'hFF) begin
                            consec_err_next = consec_err_reg + 8'd1;
                        end
                        if (consec_err_reg + 8'd1 == LOSS_LIMIT) begin
                            state_next = HUNT;
                        end
`endif
                    end
                end
                default: state_next = HUNT;
            endcase
        end
        if (err_clr) begin
            err_count_next = '0;
        end
        locked_next = (state_next == LOCKED);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= HUNT;
            expected_reg   <= 16'h0000;
            match_cnt_reg  <= 4'd0;
            locked_reg     <= 1'b0;
            err_pulse_reg  <= 1'b0;
            err_count_reg  <= '0;
`ifdef LFSR_CHECKER_RELOCK_EN
            consec_err_reg <= 8'd0;
`endif
        end else begin
            state_reg      <= state_next;
            expected_reg   <= expected_next;
            match_cnt_reg  <= match_cnt_next;
            locked_reg     <= locked_next;
            err_pulse_reg  <= err_pulse_next;
            err_count_reg  <= err_count_next;
`ifdef LFSR_CHECKER_RELOCK_EN
            consec_err_reg <= consec_err_next;
`endif
        end
    end

    assign locked    = locked_reg;
    assign err_pulse = err_pulse_reg;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: default instance plus a 4-bit error-counter instance on shared stimulus.
module tb_lfsr_checker;

    localparam int LOCK_COUNT  = 4;
    localparam int LOSS_THRESH = 8;
`ifdef LFSR_CHECKER_RELOCK_EN
    localparam bit RELOCK = 1'b1;
`else
    localparam bit RELOCK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] data_in;
    logic        data_valid;
    logic        err_clr;
    logic        locked, err_pulse;
    logic [15:0] err_count;
    logic        locked4, err_pulse4;
    logic [3:0]  err_count4;

    always #5 clk = ~clk;

    lfsr_checker #(.LOCK_COUNT(LOCK_COUNT), .LOSS_THRESH(LOSS_THRESH), .ERR_CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
        .err_clr(err_clr), .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
    );

    lfsr_checker #(.LOCK_COUNT(LOCK_COUNT), .LOSS_THRESH(LOSS_THRESH), .ERR_CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
        .err_clr(err_clr), .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4)
    );

    typedef struct {
        bit lk;
        bit pu;
        int c16;
        int c4;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   txn      = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Polynomial step as a shift plus the parity of the tapped bits.
    function automatic logic [15:0] nxt(input logic [15:0] v);
        return (v << 1) | 16'(^(v & 16'hB400));
    endfunction

    // Reference model: sequence-level view of the checker.
    bit          m_locked;
    bit          m_seeded;
    logic [15:0] m_pred;
    int          m_run, m_bad, m_cnt16, m_cnt4;

    task automatic model_reset();
        m_locked = 0; m_seeded = 0; m_pred = '0;
        m_run = 0; m_bad = 0; m_cnt16 = 0; m_cnt4 = 0;
    endtask

    task automatic model_step(input bit v, input logic [15:0] d, input bit clr);
        exp_t e;
        bit   pulse = 0;
        if (v) begin
            if (m_locked) begin
                if (d != m_pred) begin
                    pulse   = 1;
                    m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
                    m_cnt4  = (m_cnt4 < 15) ? m_cnt4 + 1 : 15;
                    m_bad   = (m_bad < 255) ? m_bad + 1 : 255;
                    if (RELOCK && m_bad >= LOSS_THRESH) begin
                        m_locked = 0;
                        m_seeded = 0;
                    end
                end else begin
                    m_bad = 0;
                end
                m_pred = nxt(m_pred);
            end else if (d == 16'h0000) begin
                m_seeded = 0;
            end else if (m_seeded && d == m_pred) begin
                m_run++;
                m_pred = nxt(d);
                if (m_run == LOCK_COUNT) begin
                    m_locked = 1;
                    m_bad    = 0;
                end
            end else begin
                m_seeded = 1;
                m_run    = 0;
                m_pred   = nxt(d);
            end
        end
        if (clr) begin
            m_cnt16 = 0;
            m_cnt4  = 0;
        end
        e.lk = m_locked; e.pu = pulse; e.c16 = m_cnt16; e.c4 = m_cnt4;
        sb.push_back(e);
    endtask

    // Monitor: one expected entry per clock edge issued by the stimulus.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            txn++;
            $display("txn %0d locked=%0b pulse=%0b cnt=%0d cnt4=%0d", txn, locked, err_pulse, err_count, err_count4);
            check("locked", int'(locked), int'(e.lk));
            check("err_pulse", int'(err_pulse), int'(e.pu));
            check("err_count", int'(err_count), e.c16);
            check("locked4", int'(locked4), int'(e.lk));
            check("err_pulse4", int'(err_pulse4), int'(e.pu));
            check("err_count4", int'(err_count4), e.c4);
        end
    end

    logic [15:0] gen;

    task automatic step(input bit v, input logic [15:0] d, input bit clr);
        @(negedge clk);
        #1;
        data_valid = v;
        data_in    = d;
        err_clr    = clr;
        model_step(v, d, clr);
    endtask

    task automatic good(input bit clr);
        step(1'b1, gen, clr);
        gen = nxt(gen);
    endtask

    task automatic bad(input logic [15:0] flip, input bit clr);
        step(1'b1, gen ^ flip, clr);
        gen = nxt(gen);
    endtask

    task automatic rand_flip(output logic [15:0] f);
        f = 16'($urandom_range(1, 65535));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_pulse"}, int'(err_pulse), 0);
        check({tag, "_count"}, int'(err_count), 0);
        check({tag, "_locked4"}, int'(locked4), 0);
        check({tag, "_count4"}, int'(err_count4), 0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #1;
        reset_n    = 1'b0;
        data_valid = 1'b0;
        err_clr    = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        model_reset();
        @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] f;
        int          r;
        bit          c;
        reset_n = 1'b0; data_valid = 1'b0; err_clr = 1'b0; data_in = '0;
        model_reset();
        #2;
        check_zero_outputs("reset");
        @(negedge clk);
        #1;
        reset_n = 1'b1;

        // All-zero words never seed.
        repeat (6) step(1'b1, 16'h0000, 1'b0);

        // Acquire from ACE1, 59C3, ...: lock after the fifth word.
        gen = 16'hACE1;
        repeat (8) good(1'b0);

        // Single bit-0 corruption while locked.
        bad(16'h0001, 1'b0);
        repeat (5) good(1'b0);

        // LOSS_THRESH consecutive errors, then a fresh sequence.
        repeat (LOSS_THRESH) begin
            rand_flip(f);
            bad(f, 1'b0);
        end
        gen = 16'h1234;
        repeat (8) good(1'b0);

        mid_reset();

        // Randomised traffic: gaps, sporadic errors, occasional clears.
        gen = 16'($urandom_range(1, 65535));
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            c = ($urandom_range(0, 99) < 3);
            if (r < 40) begin
                step(1'b0, 16'($urandom), c);
            end else if (r < 45) begin
                rand_flip(f);
                bad(f, c);
            end else begin
                good(c);
            end
        end

        // Restart cleanly and saturate the narrow counter without tripping lock loss.
        mid_reset();
        gen = 16'($urandom_range(1, 65535));
        repeat (6) good(1'b0);
        repeat (3) begin
            repeat (7) begin
                rand_flip(f);
                bad(f, 1'b0);
            end
            good(1'b0);
        end
        rand_flip(f);
        bad(f, 1'b1);
        repeat (3) good(1'b0);

        // Gaps while locked must not advance the prediction; then reset mid-lock and relock.
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 1) == 1) good(1'b0);
            else step(1'b0, 16'($urandom), 1'b0);
        end
        mid_reset();
        gen = 16'($urandom_range(1, 65535));
        repeat (7) good(1'b0);

        @(negedge clk);
        #2;
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Downstream consumer of the 16-bit `lfsr` pattern generator. It samples each generator word, self-synchronises to the sequence, and then predicts every following word. While locked it counts mismatches and reports lock status, so generator, link or memory paths can be checked in simulation and on silicon. It sits directly on the `y` bus of `lfsr`.

## Interface
- `LOCK_COUNT`, 4: consecutive correct predictions required to declare lock (range 1..15).
- `LOSS_THRESH`, 8: consecutive mismatches while locked that drop lock (range 1..255; used only with the relock feature).
- `ERR_CNT_W`, 16: width of the error counter.

Ports:
- `clk`  input  1: single clock; all state is updated on the rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `data_in`  input  [15:0]: generator word. `data_in[15]` carries `y[1]`.
- `data_valid`  input  1: `data_in` is sampled only when this is high.
- `err_clr`  input  1: synchronous clear of `err_count`.
- `locked`  output  1: checker is synchronised to the sequence.
- `err_pulse`  output  1: one-cycle flag marking a mismatch on a locked word.
- `err_count`  output  [ERR_CNT_W-1:0]: saturating count of mismatches while locked.

## Operation
- Next-state function is fixed: `nxt(v) = {v[14:0], v[15]^v[13]^v[12]^v[10]}` (x^16+x^14+x^13+x^11+1, one step per word).
- The all-zero word is an invalid seed.
- Internal state: FSM {HUNT, VERIFY, LOCKED}, `expected` [15:0], `match_cnt`, `consec_err`.
- Cycles with `data_valid`=0 change nothing except `err_clr` handling. `err_pulse` is 0 on those cycles.
- HUNT:
  - valid and `data_in`≠0: `expected`←nxt(`data_in`), `match_cnt`←0, go to VERIFY.
  - valid and `data_in`=0: stay in HUNT.
- VERIFY, valid word:
  - Match: `expected`←nxt(`data_in`), `match_cnt`+1. When the new count equals LOCK_COUNT, go to LOCKED with `consec_err`←0.
  - Mismatch with `data_in`≠0: reseed from `data_in`, `match_cnt`←0, stay in VERIFY.
  - Mismatch with `data_in`=0: go to HUNT.
  - No errors are counted in VERIFY.
- LOCKED, valid word:
  - `expected`←nxt(`expected`). The checker free-runs and never reseeds from received data.
  - Match: `consec_err`←0.
  - Mismatch: `err_pulse`←1, `err_count` increments and saturates at all-ones, `consec_err` increments and saturates at 255.
- `err_clr`: `err_count`←0 in any state. If `err_clr` and a counted mismatch occur in the same cycle, the clear wins (count = 0), but `err_pulse` still asserts.
- Reset mid-operation: all state returns to reset values immediately. The sequence must be reacquired from HUNT.

## Timing
- Reset values: `locked`=0, `err_pulse`=0, `err_count`=0, FSM=HUNT, `expected`=0, counters=0.
- All outputs are registered, with no combinational input-to-output path.
- `err_pulse` is high in the cycle after the edge that sampled the erroring word, for exactly one cycle per erroring word. Back-to-back errors give a continuous high level.
- `err_count` reflects a mismatch in the same cycle as its `err_pulse`.
- Lock latency, with `data_valid` held high from edge 0:
  - Seed is sampled at edge 0.
  - Matches are sampled at edges 1..LOCK_COUNT.
  - `locked` is high after edge LOCK_COUNT (4 by default).
- Lock loss: `locked` falls after the edge sampling the LOSS_THRESH-th consecutive mismatch. That word is counted. The FSM enters HUNT, and the next valid word is a seed.

## Configuration
- `LFSR_CHECKER_RELOCK_EN` defined: lock-loss logic is compiled in, behaving as described above (LOCKED→HUNT after LOSS_THRESH consecutive mismatches).
- `LFSR_CHECKER_RELOCK_EN` undefined: LOCKED is terminal until `reset_n`. `consec_err` and LOSS_THRESH logic are removed, while errors are still counted and pulsed.

## Test plan
- Feed 16'hACE1, 16'h59C3, then successive nxt() words with `data_valid`=1 → `locked`=1 after the 5th word, `err_count`=0, `err_pulse` never high.
- Locked, replace one word with its bit-0 inverse → exactly one `err_pulse`, `err_count`=1, following correct words give no further errors.
- Locked, with relock enabled and LOSS_THRESH=8, feed 8 wrong words → `err_count`=8 and `locked` falls after the 8th. A fresh valid sequence then relocks after 5 words. The same stimulus with the macro undefined → `locked` stays 1.
- Feed 16'h0000 repeatedly → FSM stays in HUNT, `locked`=0.
- ERR_CNT_W=4, 20 errors → `err_count` holds at 4'hF. Pulse `err_clr` together with an error → `err_count`=0 and `err_pulse`=1 in that cycle.
- Toggle `data_valid` randomly during lock, then deassert `reset_n` mid-lock → invalid cycles do not advance `expected`. After reset, all outputs are 0 immediately and relock takes 5 valid words.
